// File: rtl/switch_debounce.sv
// switch_debounce: input conditioning for 8 slide switches and 1 push button.
// Every raw pin passes through a 2-FF synchroniser and a per-channel stability
// counter. A channel output only follows the pin after the synchronised level
// has differed from it for STABLE_COUNT consecutive cycles.
//
// Ports:
//   Clk      - system clock; all state updates on the rising edge
//   Rst      - synchronous, active-high reset
//   SwIn     - raw switch pins, SwIn[i] = switch i
//   BtnIn    - raw button pin, 1 = pressed
//   SwDb     - debounced switch levels
//   BtnDb    - debounced button level
//   BtnPress - one-cycle pulse after BtnDb rises (BTN_PULSE_EN builds only)
//
// Build option: define BTN_PULSE_EN to build the press-pulse edge detector.
// Without it, BtnPress is tied to 0.
//
// Parameters:
//   CNT_WIDTH    - width of each stability counter
//   STABLE_COUNT - cycles a changed level must persist; 1 <= STABLE_COUNT < 2**CNT_WIDTH

// One debounce channel: synchroniser, stability counter, registered level.
module switch_debounce_chan #(
  parameter int CNT_WIDTH    = 16,
  parameter int STABLE_COUNT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic q
);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_COUNT - 1);

  logic                 s1, s2;
  logic [CNT_WIDTH-1:0] cnt;

  // cnt counts consecutive mismatch cycles; it is cleared on every match and
  // whenever q updates, so it never passes LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      q   <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 == q) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        q   <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end
endmodule

module switch_debounce #(
  parameter int CNT_WIDTH    = 16,
  parameter int STABLE_COUNT = 50000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] SwIn,
  input  logic       BtnIn,
  output logic [7:0] SwDb,
  output logic       BtnDb,
  output logic       BtnPress
);
  localparam int NUM_CH = 9;

  // Channels 0..7 are the switches, channel 8 is the button.
  logic [NUM_CH-1:0] pin, q;

  assign pin = {BtnIn, SwIn};

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      switch_debounce_chan #(
        .CNT_WIDTH   (CNT_WIDTH),
        .STABLE_COUNT(STABLE_COUNT)
      ) u_ch (
        .clk(Clk),
        .rst(Rst),
        .pin(pin[i]),
        .q  (q[i])
      );
    end
  endgenerate

  assign SwDb  = q[7:0];
  assign BtnDb = q[8];

`ifdef BTN_PULSE_EN
  logic btn_prev;

  // Pulse fires the cycle after BtnDb rises; release and hold give nothing.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      btn_prev <= 1'b0;
      BtnPress <= 1'b0;
    end else begin
      btn_prev <= BtnDb;
      BtnPress <= BtnDb & ~btn_prev;
    end
  end
`else
  assign BtnPress = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with STABLE_COUNT=4, CNT_WIDTH=4.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. they show the state produced by the edge just taken.
module tb_switch_debounce;
  localparam int SC = 4;
`ifdef BTN_PULSE_EN
  localparam int PULSE = 1;
`else
  localparam int PULSE = 0;
`endif

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] SwIn;
  logic       BtnIn;
  logic [7:0] SwDb;
  logic       BtnDb;
  logic       BtnPress;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  switch_debounce #(
    .CNT_WIDTH   (4),
    .STABLE_COUNT(SC)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .SwIn    (SwIn),
    .BtnIn   (BtnIn),
    .SwDb    (SwDb),
    .BtnDb   (BtnDb),
    .BtnPress(BtnPress)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  int npulse, rise_step, pulse_step;
  logic prev_db;

  initial begin
    // Reset with every pin high
    Rst = 1'b1; SwIn = 8'hFF; BtnIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_sw", SwDb, 8'h00);
      chk("rst_btn", BtnDb, 0);
      chk("rst_press", BtnPress, 0);
    end
    Rst = 1'b0;
    // Next edge is N; outputs follow at N+5 (6th step)
    for (int i = 1; i <= SC + 1; i++) begin
      step();
      chk("rel_sw_hold", SwDb, 8'h00);
      chk("rel_btn_hold", BtnDb, 0);
    end
    step();
    chk("rel_sw_rise", SwDb, 8'hFF);
    chk("rel_btn_rise", BtnDb, 1);
    chk("rel_press_pre", BtnPress, 0);
    step();
    chk("rel_press", BtnPress, PULSE);
    step();
    chk("rel_press_end", BtnPress, 0);

    // Clean change 00 -> A5
    SwIn = 8'h00; BtnIn = 1'b0;
    repeat (8) step();
    chk("clean_base", SwDb, 8'h00);
    chk("clean_btn_base", BtnDb, 0);
    SwIn = 8'hA5;
    for (int i = 1; i <= SC + 1; i++) begin
      step();
      chk("clean_hold", SwDb, 8'h00);
    end
    step();
    chk("clean_rise", SwDb, 8'hA5);

    // Glitch: 3 cycles high is rejected
    BtnIn = 1'b1;
    repeat (3) step();
    chk("glitch_btn_a", BtnDb, 0);
    BtnIn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("glitch_btn", BtnDb, 0);
      chk("glitch_press", BtnPress, 0);
    end
    // 4 cycles high is accepted at N+5
    BtnIn = 1'b1;
    for (int i = 1; i <= SC + 1; i++) begin
      step();
      if (i == SC) BtnIn = 1'b0;
      chk("btn4_hold", BtnDb, 0);
    end
    step();
    chk("btn4_rise", BtnDb, 1);
    step();
    chk("btn4_press", BtnPress, PULSE);
    repeat (10) step();
    chk("btn4_fall", BtnDb, 0);
    chk("btn4_sw", SwDb, 8'hA5);

    // Bounce on SwIn[3]: 1,0,1,0 then final 1 held
    for (int i = 0; i < 4; i++) begin
      SwIn[3] = (i % 2 == 0);
      step();
      chk("bounce_mid", SwDb, 8'hA5);
    end
    SwIn[3] = 1'b1;
    for (int i = 1; i <= SC + 1; i++) begin
      step();
      chk("bounce_hold", SwDb, 8'hA5);
    end
    step();
    chk("bounce_rise", SwDb, 8'hAD);

    // Press pulse: 20 high, 20 low
    npulse = 0; rise_step = -1; pulse_step = -1; prev_db = BtnDb;
    for (int i = 0; i < 40; i++) begin
      BtnIn = (i < 20);
      step();
      if (BtnDb && !prev_db) rise_step = i;
      if (BtnPress) begin
        npulse++;
        pulse_step = i;
      end
      prev_db = BtnDb;
    end
    chk("press_cnt", npulse, PULSE);
    chk("press_seen_rise", (rise_step >= 0), 1);
    chk("press_at", pulse_step, (PULSE != 0) ? rise_step + 1 : -1);
    chk("press_btn_end", BtnDb, 0);

    // Reset mid-count on SwIn[0]
    SwIn = 8'h00;
    repeat (8) step();
    chk("midrst_base", SwDb, 8'h00);
    SwIn = 8'h01;
    step();                 // edge N: s1 samples 1
    step();                 // edge N+1
    Rst = 1'b1;
    step();                 // edge N+2 resets
    chk("midrst_rst", SwDb, 8'h00);
    chk("midrst_press", BtnPress, 0);
    Rst = 1'b0;
    for (int i = 1; i <= SC + 1; i++) begin
      step();
      chk("midrst_hold", SwDb, 8'h00);
    end
    step();
    chk("midrst_rise", SwDb, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
